// File: rtl/csr_file_m_if.sv
// CSR access bus between the commit stage (master) and csr_file_m (slave).
// Carries the committing CSR instruction and its combinational read-back.
interface csr_file_m_if;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (output csr_addr, csr_op, csr_wdata, input csr_rdata, csr_illegal);
    modport slave  (input csr_addr, csr_op, csr_wdata, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_file_m.sv
// Machine/user CSR file: counters, trap/mret sequencing and interrupt gating at commit.
// Optional feature: define CSR_MTVEC_VECTORED_EN for vectored mtvec (mtvec[0] = mode).
//
// state  | meaning
// PRIV_U | user mode: only CSRs with addr[9:8] == 00 accessible, mret illegal
// PRIV_M | machine mode: full access, entered on reset and on every trap
module csr_file_m #(
    parameter int          RETIRE_WIDTH = 2,
    parameter logic [31:0] HART_ID      = 32'h0,
    parameter logic [31:0] MISA_VAL     = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET  = 32'h0,
    localparam int         RCW          = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    csr_file_m_if.slave      csr_if,
    input  logic [RCW-1:0]   retire_cnt_i,
    input  logic             trap_valid_i,
    input  logic             trap_irq_i,
    input  logic             trap_ecall_i,
    input  logic [4:0]       trap_cause_i,
    input  logic [31:0]      trap_pc_i,
    input  logic [31:0]      trap_tval_i,
    input  logic             mret_valid_i,
    input  logic             timer_irq_i,
    input  logic             ext_irq_i,
    output logic [31:0]      trap_target_o,
    output logic [31:0]      mepc_out_o,
    output logic [1:0]       curr_priv_o,
    output logic             irq_pending_o,
    output logic             mret_illegal_o
);

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_e;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    priv_e       priv_q, priv_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [1:0]  mpp_q, mpp_d;
    logic        mtie_q, mtie_d, meie_q, meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] mstatus_w, mie_w, mip_w, old_val, wval;
    logic        mapped, illegal, wr_en, mret_ok;
    logic [11:0] addr;

    assign addr      = csr_if.csr_addr;
    assign mstatus_w = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
    assign mie_w     = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
    assign mip_w     = {20'b0, ext_irq_i, 3'b0, timer_irq_i, 7'b0};

    always_comb begin
        mapped  = 1'b1;
        old_val = 32'h0;
        case (addr)
            12'h300:          old_val = mstatus_w;
            12'h301:          old_val = MISA_VAL;
            12'h304:          old_val = mie_w;
            12'h305:          old_val = mtvec_q;
            12'h340:          old_val = mscratch_q;
            12'h341:          old_val = mepc_q;
            12'h342:          old_val = mcause_q;
            12'h343:          old_val = mtval_q;
            12'h344:          old_val = mip_w;
            12'hB00, 12'hC00: old_val = mcycle_q[31:0];
            12'hB80, 12'hC80: old_val = mcycle_q[63:32];
            12'hB02, 12'hC02: old_val = minstret_q[31:0];
            12'hB82, 12'hC82: old_val = minstret_q[63:32];
            12'hF14:          old_val = HART_ID;
            default:          mapped  = 1'b0;
        endcase
    end

    always_comb begin
        illegal = (csr_if.csr_op != OP_NONE) &&
                  (!mapped ||
                   (priv_q == PRIV_U && addr[9:8] != 2'b00) ||
                   (addr[11:10] == 2'b11 &&
                    (csr_if.csr_op == OP_RW || csr_if.csr_wdata != 32'h0)));
        case (csr_if.csr_op)
            OP_RW:   wval = csr_if.csr_wdata;
            OP_RS:   wval = old_val | csr_if.csr_wdata;
            OP_RC:   wval = old_val & ~csr_if.csr_wdata;
            default: wval = old_val;
        endcase
    end

    assign csr_if.csr_illegal = illegal;
    assign csr_if.csr_rdata   = (csr_if.csr_op != OP_NONE && !illegal) ? old_val : 32'h0;

    // RS/RC with a zero operand is a pure read and must not disturb counters.
    assign mret_ok = mret_valid_i && priv_q == PRIV_M && !trap_valid_i;
    assign wr_en   = csr_if.csr_op != OP_NONE && !illegal && !trap_valid_i && !mret_ok &&
                     (csr_if.csr_op == OP_RW || csr_if.csr_wdata != 32'h0);

    // Privilege FSM: state register
    always_ff @(posedge clk) begin
        if (reset) priv_q <= PRIV_M;
        else       priv_q <= priv_d;
    end

    // Privilege FSM: next state
    always_comb begin
        priv_d = priv_q;
        if (trap_valid_i)  priv_d = PRIV_M;
        else if (mret_ok)  priv_d = (mpp_q == 2'b11) ? PRIV_M : PRIV_U;
    end

    // Privilege FSM: outputs
    always_comb begin
        curr_priv_o    = priv_q;
        mret_illegal_o = mret_valid_i && priv_q == PRIV_U;
        irq_pending_o  = (|(mip_w & mie_w)) && (priv_q == PRIV_U || mie_q);
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mpp_d      = mpp_q;
        mtie_d     = mtie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + 64'(retire_cnt_i);

        if (trap_valid_i) begin
            mepc_d   = {trap_pc_i[31:2], 2'b00};
            mtval_d  = trap_tval_i;
            mcause_d = trap_ecall_i ? ((priv_q == PRIV_U) ? 32'd8 : 32'd11)
                                    : {trap_irq_i, 26'b0, trap_cause_i};
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = priv_q;
        end else if (mret_ok) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            mpp_d  = 2'b00;
        end else if (wr_en) begin
            case (addr)
                12'h300: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                    mpp_d  = (wval[12:11] == 2'b11) ? 2'b11 : 2'b00;
                end
                12'h304: begin
                    mtie_d = wval[7];
                    meie_d = wval[11];
                end
`ifdef CSR_MTVEC_VECTORED_EN
                12'h305: mtvec_d = {wval[31:2], 1'b0, wval[0]};
`else
                12'h305: mtvec_d = {wval[31:2], 2'b00};
`endif
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = {wval[31:2], 2'b00};
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
                12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wval};
                12'hB82: minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mpp_q      <= 2'b00;
            mtie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mpp_q      <= mpp_d;
            mtie_q     <= mtie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    always_comb begin
        trap_target_o = {mtvec_q[31:2], 2'b00};
`ifdef CSR_MTVEC_VECTORED_EN
        if (mtvec_q[0] && trap_irq_i)
            trap_target_o = {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause_i, 2'b00};
`endif
    end

    assign mepc_out_o = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m: counters, WARL masks, privilege, traps and mret.
// Honours CSR_MTVEC_VECTORED_EN in the mtvec/trap_target expectations.
module tb_csr_file_m;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  retire_cnt;
    logic        trap_valid, trap_irq, trap_ecall, mret_valid, timer_irq, ext_irq;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc, trap_tval;
    logic [31:0] trap_target, mepc_out;
    logic [1:0]  curr_priv;
    logic        irq_pending, mret_illegal;

    int     vectors = 0;
    int     miscompares = 0;
    longint tb_cyc = 0;
    longint wr_cyc = 0;
    logic [31:0] v;

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    csr_file_m_if bus ();

    csr_file_m dut (
        .clk            (clk),
        .reset          (reset),
        .csr_if         (bus.slave),
        .retire_cnt_i   (retire_cnt),
        .trap_valid_i   (trap_valid),
        .trap_irq_i     (trap_irq),
        .trap_ecall_i   (trap_ecall),
        .trap_cause_i   (trap_cause),
        .trap_pc_i      (trap_pc),
        .trap_tval_i    (trap_tval),
        .mret_valid_i   (mret_valid),
        .timer_irq_i    (timer_irq),
        .ext_irq_i      (ext_irq),
        .trap_target_o  (trap_target),
        .mepc_out_o     (mepc_out),
        .curr_priv_o    (curr_priv),
        .irq_pending_o  (irq_pending),
        .mret_illegal_o (mret_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Side-effect-free read: RS with a zero operand.
    task automatic rd(input logic [11:0] a, output logic [31:0] val);
        bus.csr_addr  = a;
        bus.csr_op    = 2'b10;
        bus.csr_wdata = 32'h0;
        #1;
        val = bus.csr_rdata;
        bus.csr_op = 2'b00;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = d;
        #1;
        tick();
        bus.csr_op = 2'b00;
    endtask

    initial begin
        bus.csr_addr = 12'h0; bus.csr_op = 2'b00; bus.csr_wdata = 32'h0;
        retire_cnt = 2'd0; trap_valid = 1'b0; trap_irq = 1'b0; trap_ecall = 1'b0;
        trap_cause = 5'd0; trap_pc = 32'h0; trap_tval = 32'h0; mret_valid = 1'b0;
        timer_irq = 1'b0; ext_irq = 1'b0;

        tick(); tick();
        check("rst_priv", 64'(curr_priv), 64'h3);
        check("rst_mepc", 64'(mepc_out), 64'h0);
        check("rst_irq_pending", 64'(irq_pending), 64'h0);
        check("rst_mret_illegal", 64'(mret_illegal), 64'h0);
        check("rst_csr_illegal_idle", 64'(bus.csr_illegal), 64'h0);
        rd(12'h305, v); check("rst_mtvec", 64'(v), 64'h0);
        rd(12'h300, v); check("rst_mstatus", 64'(v), 64'h0);
        rd(12'h301, v); check("misa", 64'(v), 64'h4000_0100);
        rd(12'hF14, v); check("mhartid", 64'(v), 64'h0);

        // 10 cycles with two retirements each
        reset = 1'b0;
        retire_cnt = 2'd2;
        repeat (10) tick();
        retire_cnt = 2'd0;
        rd(12'hB00, v); check("mcycle_10", 64'(v), 64'd10);
        rd(12'hB02, v); check("minstret_20", 64'(v), 64'd20);
        rd(12'hC00, v); check("cycle_alias", 64'(v), 64'd10);
        rd(12'hB80, v); check("mcycleh_0", 64'(v), 64'h0);

        // mtvec WARL
        bus.csr_addr = 12'h305; bus.csr_op = 2'b01; bus.csr_wdata = 32'h8000_0103;
        #1;
        check("mtvec_rw_old", 64'(bus.csr_rdata), 64'h0);
        tick();
        bus.csr_op = 2'b00;
        rd(12'h305, v);
`ifdef CSR_MTVEC_VECTORED_EN
        check("mtvec_warl", 64'(v), 64'h8000_0101);
`else
        check("mtvec_warl", 64'(v), 64'h8000_0100);
`endif

        // minstret wrap and same-cycle mcycle write
        wr(2'b01, 12'hB02, 32'hFFFF_FFFF);
        wr(2'b01, 12'hB82, 32'hFFFF_FFFF);
        rd(12'hB02, v); check("minstret_lo_max", 64'(v), 64'hFFFF_FFFF);
        rd(12'hB82, v); check("minstret_hi_max", 64'(v), 64'hFFFF_FFFF);
        retire_cnt = 2'd1;
        bus.csr_addr = 12'hB00; bus.csr_op = 2'b01; bus.csr_wdata = 32'h1234_5678;
        #1;
        tick();
        wr_cyc = tb_cyc;
        bus.csr_op = 2'b00;
        retire_cnt = 2'd0;
        rd(12'hB02, v); check("minstret_wrap_lo", 64'(v), 64'h0);
        rd(12'hB82, v); check("minstret_wrap_hi", 64'(v), 64'h0);
        rd(12'hB00, v); check("mcycle_written", 64'(v), 64'h1234_5678);
        rd(12'hB80, v); check("mcycleh_unchanged", 64'(v), 64'h0);

        // WARL masks
        wr(2'b01, 12'h341, 32'h0000_0203);
        rd(12'h341, v); check("mepc_warl", 64'(v), 64'h200);
        check("mepc_out", 64'(mepc_out), 64'h200);
        wr(2'b01, 12'h304, 32'hFFFF_FFFF);
        rd(12'h304, v); check("mie_warl", 64'(v), 64'h880);
        wr(2'b11, 12'h304, 32'h0000_0800);
        rd(12'h304, v); check("mie_rc", 64'(v), 64'h80);
        wr(2'b01, 12'h300, 32'hFFFF_FFFF);
        rd(12'h300, v); check("mstatus_warl", 64'(v), 64'h1888);
        wr(2'b01, 12'h300, 32'h0000_1000);
        rd(12'h300, v); check("mstatus_mpp10", 64'(v), 64'h0);

        // illegal accesses in M mode
        bus.csr_addr = 12'h7C0; bus.csr_op = 2'b01; bus.csr_wdata = 32'h1;
        #1;
        check("unmapped_illegal", 64'(bus.csr_illegal), 64'h1);
        check("unmapped_rdata", 64'(bus.csr_rdata), 64'h0);
        bus.csr_addr = 12'hF14;
        #1;
        check("ro_rw_illegal", 64'(bus.csr_illegal), 64'h1);
        bus.csr_op = 2'b00;

        wr(2'b01, 12'h305, 32'h0000_0101);

        // interrupt gating in M with MIE=0
        timer_irq = 1'b1;
        #1;
        check("irq_gated_m", 64'(irq_pending), 64'h0);
        rd(12'h344, v); check("mip_live", 64'(v), 64'h80);

        // mret to U (MPP=00)
        mret_valid = 1'b1;
        #1;
        check("mret_legal", 64'(mret_illegal), 64'h0);
        tick();
        mret_valid = 1'b0;
        check("priv_u", 64'(curr_priv), 64'h0);
        check("irq_pending_u", 64'(irq_pending), 64'h1);

        mret_valid = 1'b1;
        #1;
        check("mret_illegal_u", 64'(mret_illegal), 64'h1);
        tick();
        mret_valid = 1'b0;
        check("priv_stays_u", 64'(curr_priv), 64'h0);

        // U-mode CSR accesses
        bus.csr_addr = 12'h300; bus.csr_op = 2'b10; bus.csr_wdata = 32'h8;
        #1;
        check("u_mstatus_illegal", 64'(bus.csr_illegal), 64'h1);
        check("u_mstatus_rdata", 64'(bus.csr_rdata), 64'h0);
        tick();
        bus.csr_addr = 12'hC00; bus.csr_op = 2'b10; bus.csr_wdata = 32'h0;
        #1;
        check("u_cycle_legal", 64'(bus.csr_illegal), 64'h0);
        check("u_cycle_rdata", 64'(bus.csr_rdata),
              64'(32'(64'h1234_5678 + tb_cyc - wr_cyc)));
        bus.csr_op = 2'b00;

        // timer interrupt trap from U
        trap_valid = 1'b1; trap_irq = 1'b1; trap_cause = 5'd7;
        trap_pc = 32'h0000_0400; trap_tval = 32'h0;
        #1;
`ifdef CSR_MTVEC_VECTORED_EN
        check("trap_target_vec", 64'(trap_target), 64'h11C);
`else
        check("trap_target_dir", 64'(trap_target), 64'h100);
`endif
        tick();
        trap_valid = 1'b0; trap_irq = 1'b0; trap_cause = 5'd0;
        timer_irq = 1'b0;
        check("priv_m_after_irq", 64'(curr_priv), 64'h3);
        rd(12'h342, v); check("mcause_irq", 64'(v), 64'h8000_0007);
        rd(12'h300, v); check("mstatus_after_irq", 64'(v), 64'h0);
        check("mepc_irq", 64'(mepc_out), 64'h400);

        // ecall from M with MIE=1, concurrent CSR write dropped
        wr(2'b10, 12'h300, 32'h8);
        trap_valid = 1'b1; trap_ecall = 1'b1; trap_pc = 32'h0000_0107; trap_tval = 32'h0000_DEAD;
        bus.csr_addr = 12'h340; bus.csr_op = 2'b01; bus.csr_wdata = 32'h55;
        #1;
        tick();
        trap_valid = 1'b0; trap_ecall = 1'b0;
        bus.csr_op = 2'b00;
        check("ecall_mepc", 64'(mepc_out), 64'h104);
        rd(12'h342, v); check("ecall_mcause", 64'(v), 64'd11);
        rd(12'h300, v); check("ecall_mstatus", 64'(v), 64'h1880);
        rd(12'h343, v); check("ecall_mtval", 64'(v), 64'hDEAD);
        rd(12'h340, v); check("mscratch_dropped", 64'(v), 64'h0);

        // mret back to M
        mret_valid = 1'b1;
        #1;
        tick();
        mret_valid = 1'b0;
        check("mret_priv_m", 64'(curr_priv), 64'h3);
        rd(12'h300, v); check("mret_mstatus", 64'(v), 64'h88);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
